// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write path.
// Write requests travel as a packed {addr, data} pair.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 64;
   localparam int XZR        = 31;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wr_req_t;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_id_t;

endpackage

// File: rtl/regfile_write_arbiter_buf.sv
// Single-entry holding buffer for one writeback source.
// If load and clear arrive together, the load wins, so a drained entry can refill at the same edge.
module wr_req_buffer
   import regfile_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    load,
   input  logic    clear,
   input  wr_req_t load_req,
   output logic    valid,
   output wr_req_t req
);

   logic    valid_q, valid_d;
   wr_req_t req_q, req_d;

   always_comb begin
      valid_d = valid_q;
      req_d   = req_q;
      if (load) begin
         valid_d = 1'b1;
         req_d   = load_req;
      end else if (clear) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         req_q   <= '0;
      end else begin
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   assign valid = valid_q;
   assign req   = req_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the ALU and memory writeback sources onto the single register file write port.
// Same-register writes leave in arrival order; otherwise grants alternate round-robin.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_W,
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int ZERO_REG   = XZR
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [DATA_WIDTH-1:0] req_data0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   input  logic [DATA_WIDTH-1:0] req_data1,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [31:0]           busy_mask
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   wr_req_t               in_req  [2];
   wr_req_t               buf_req [2];
   logic [1:0]            buf_valid, grant, accept, load, next_valid;
   logic [1:0]            young_q, young_d;
   req_id_t               rr_q, rr_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   assign in_req[0] = '{addr: req_addr0, data: req_data0};
   assign in_req[1] = '{addr: req_addr1, data: req_data1};

   for (genvar i = 0; i < 2; i++) begin : g_buf
      wr_req_buffer u_buf (
         .clk      (clk),
         .reset    (reset),
         .load     (load[i]),
         .clear    (grant[i]),
         .load_req (in_req[i]),
         .valid    (buf_valid[i]),
         .req      (buf_req[i])
      );
   end

   // young_q[i] marks buffer i as the later arrival when both hold writes.
   always_comb begin
      grant = buf_valid;
      if (&buf_valid) begin
         if (buf_req[0].addr == buf_req[1].addr) grant = young_q[0] ? 2'b10 : 2'b01;
         else                                    grant = (rr_q == REQ_ALU) ? 2'b01 : 2'b10;
      end
   end

   assign req_ready = reset ? 2'b00 : (~buf_valid | grant);
   assign accept    = req_valid & req_ready;

   always_comb begin
      for (int i = 0; i < 2; i++) load[i] = accept[i] && (in_req[i].addr != ZERO_ADDR);
   end

   // Simultaneous loads treat the ALU write as older.
   always_comb begin
      next_valid = (buf_valid & ~grant) | load;
      young_d    = young_q;
      if (!(&next_valid)) young_d = 2'b00;
      else if (&load)     young_d = 2'b10;
      else if (load[0])   young_d = 2'b01;
      else if (load[1])   young_d = 2'b10;
   end

   always_comb begin
      rr_d      = rr_q;
      wr_en_d   = |grant;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (grant[0]) begin
         rr_d      = REQ_MEM;
         wr_addr_d = buf_req[0].addr;
         wr_data_d = buf_req[0].data;
      end else if (grant[1]) begin
         rr_d      = REQ_ALU;
         wr_addr_d = buf_req[1].addr;
         wr_data_d = buf_req[1].data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         young_q   <= 2'b00;
         rr_q      <= REQ_ALU;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         young_q   <= young_d;
         rr_q      <= rr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < 2; i++) begin
         if (buf_valid[i]) busy_mask[buf_req[i].addr] = 1'b1;
      end
      if (wr_en_q) busy_mask[wr_addr_q] = 1'b1;
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic, all checked
// against a sequence-number based model of the pending writes.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [4:0]  req_addr0, req_addr1;
   logic [63:0] req_data0, req_data1;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic [31:0] busy_mask;

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr0 (req_addr0),
      .req_data0 (req_data0),
      .req_addr1 (req_addr1),
      .req_data1 (req_data1),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy_mask (busy_mask)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: each pending write carries an arrival sequence number.
   bit          m_valid [2];
   logic [4:0]  m_addr  [2];
   logic [63:0] m_data  [2];
   int          m_seq   [2];
   int          seq_ctr = 0;
   int          m_rr = 0;
   bit          m_out_en = 0;
   logic [4:0]  m_out_addr = '0;
   logic [63:0] m_out_data = '0;
   logic [68:0] exp_q [$];
   logic [68:0] got_q [$];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) m_valid[i] = 0;
      m_rr       = 0;
      m_out_en   = 0;
      m_out_addr = '0;
      m_out_data = '0;
      exp_q.delete();
   endtask

   // Called just after a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      int          g;
      bit          rdy [2];
      logic [4:0]  a [2];
      logic [63:0] d [2];
      logic [31:0] mask;
      logic [68:0] e;
      #1;
      a[0] = req_addr0; a[1] = req_addr1;
      d[0] = req_data0; d[1] = req_data1;
      g = -1;
      if (m_valid[0] && m_valid[1]) begin
         if (m_addr[0] == m_addr[1]) g = (m_seq[0] < m_seq[1]) ? 0 : 1;
         else g = m_rr;
      end else if (m_valid[0]) g = 0;
      else if (m_valid[1]) g = 1;
      for (int i = 0; i < 2; i++) rdy[i] = !reset && (!m_valid[i] || g == i);
      check_val("req_ready", req_ready, {rdy[1], rdy[0]});
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         m_out_en = (g >= 0);
         if (g >= 0) begin
            m_out_addr = m_addr[g];
            m_out_data = m_data[g];
            exp_q.push_back({m_addr[g], m_data[g]});
            m_valid[g] = 0;
            m_rr = 1 - g;
         end
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && rdy[i] && a[i] != 5'd31) begin
               m_valid[i] = 1;
               m_addr[i]  = a[i];
               m_data[i]  = d[i];
               m_seq[i]   = seq_ctr++;
            end
         end
      end
      @(negedge clk);
      mask = '0;
      for (int i = 0; i < 2; i++) if (m_valid[i]) mask[m_addr[i]] = 1'b1;
      if (m_out_en) mask[m_out_addr] = 1'b1;
      check_val("wr_en", wr_en, m_out_en);
      check_val("wr_addr", wr_addr, m_out_addr);
      check_val("wr_data", wr_data, m_out_data);
      check_val("busy_mask", busy_mask, mask);
      if (wr_en) got_q.push_back({wr_addr, wr_data});
      if (m_out_en) begin
         e = exp_q.pop_front();
         check_val("port_write", {wr_addr, wr_data}, e);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                        input logic [4:0] a1, input logic [63:0] d1);
      req_valid = v;
      req_addr0 = a0; req_data0 = d0;
      req_addr1 = a1; req_data1 = d1;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      logic [68:0] want [3];
      reset = 1'b1;
      req_valid = 2'b00;
      req_addr0 = '0; req_data0 = '0; req_addr1 = '0; req_data1 = '0;
      @(negedge clk);

      // Reset with both requesters asserting valid
      for (int i = 0; i < 3; i++) drive(2'b11, 5'd1, 64'h11, 5'd2, 64'h22);
      check_val("reset_ready", req_ready, 2'b00);
      check_val("reset_wr_en", wr_en, 1'b0);
      check_val("reset_busy", busy_mask, 32'd0);
      reset = 1'b0;
      idle(1);
      check_val("release_ready", req_ready, 2'b11);

      // Single write latency and busy window
      drive(2'b01, 5'd3, 64'hDEAD_BEEF, 5'd0, 64'd0);
      check_val("lat_busy_e", busy_mask[3], 1'b1);
      check_val("lat_wr_en_e", wr_en, 1'b0);
      idle(1);
      check_val("lat_wr_en", wr_en, 1'b1);
      check_val("lat_wr_addr", wr_addr, 5'd3);
      check_val("lat_wr_data", wr_data, 64'hDEAD_BEEF);
      check_val("lat_busy_e1", busy_mask[3], 1'b1);
      idle(1);
      check_val("lat_busy_e2", busy_mask[3], 1'b0);
      check_val("lat_wr_en_e2", wr_en, 1'b0);

      // Both streaming to different registers: port alternates 1,2,1,2
      do_reset();
      got_q.delete();
      for (int i = 0; i < 10; i++) drive(2'b11, 5'd1, 64'(100 + i), 5'd2, 64'(200 + i));
      check_val("contend_count", got_q.size() >= 8, 1'b1);
      for (int k = 0; k < 8; k++) begin
         if (k < got_q.size()) check_val("contend_order", got_q[k][68:64], (k % 2 == 0) ? 5'd1 : 5'd2);
      end
      idle(3);

      // Same register: earlier arrival from requester 1 is written first
      do_reset();
      got_q.delete();
      drive(2'b10, 5'd0, 64'd0, 5'd7, 64'hAAAA);
      drive(2'b01, 5'd7, 64'hBBBB, 5'd0, 64'd0);
      idle(3);
      want[0] = {5'd7, 64'hAAAA};
      want[1] = {5'd7, 64'hBBBB};
      check_val("age_count", got_q.size(), 2);
      for (int k = 0; k < 2; k++) if (k < got_q.size()) check_val("age_order", got_q[k], want[k]);

      // Same register while both buffers are occupied
      do_reset();
      got_q.delete();
      drive(2'b11, 5'd1, 64'h1111, 5'd7, 64'hAAAA);
      drive(2'b01, 5'd7, 64'hBBBB, 5'd0, 64'd0);
      idle(4);
      want[0] = {5'd1, 64'h1111};
      want[1] = {5'd7, 64'hAAAA};
      want[2] = {5'd7, 64'hBBBB};
      check_val("age2_count", got_q.size(), 3);
      for (int k = 0; k < 3; k++) if (k < got_q.size()) check_val("age2_order", got_q[k], want[k]);

      // XZR write: handshake only
      check_val("xzr_ready", req_ready[0], 1'b1);
      drive(2'b01, 5'd31, 64'd5, 5'd0, 64'd0);
      check_val("xzr_busy", busy_mask, 32'd0);
      idle(1);
      check_val("xzr_wr_en", wr_en, 1'b0);
      check_val("xzr_busy2", busy_mask, 32'd0);

      // Reset while both buffers hold writes
      drive(2'b11, 5'd4, 64'h4444, 5'd9, 64'h9999);
      check_val("pre_reset_busy", busy_mask, 32'h0000_0210);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check_val("midrst_busy", busy_mask, 32'd0);
      for (int i = 0; i < 2; i++) begin
         idle(1);
         check_val("midrst_wr_en", wr_en, 1'b0);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         drive(2'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3)), {$urandom, $urandom},
               ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3)), {$urandom, $urandom});
      end
      reset = 1'b0;
      idle(4);
      check_val("drain_empty", exp_q.size(), 0);
      check_val("drain_busy", busy_mask, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x64 ARM register file between two writeback sources: requester 0 (ALU/execute) and requester 1 (memory/load). Each source has a valid/ready handshake into a one-entry holding buffer. Buffered writes are granted round-robin, with same-register writes kept in arrival order. Drives the register file RegWrite/address/data port one write per cycle and publishes a busy mask of registers with in-flight writes for hazard logic.

Parameters:
DATA_WIDTH, 64, write data width
ADDR_WIDTH, 5, register index width
ZERO_REG, 31, index of XZR; writes to it are accepted and discarded

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  2  per-requester write request valid (bit 0 = ALU, bit 1 = memory)
req_ready  output  2  per-requester ready; a transfer occurs when valid && ready at a rising edge
req_addr0  input  ADDR_WIDTH  requester 0 destination register
req_data0  input  DATA_WIDTH  requester 0 write data
req_addr1  input  ADDR_WIDTH  requester 1 destination register
req_data1  input  DATA_WIDTH  requester 1 write data
wr_en  output  1  register file write enable (registered)
wr_addr  output  ADDR_WIDTH  register file write index (registered)
wr_data  output  DATA_WIDTH  register file write data (registered)
busy_mask  output  32  bit r = 1 while a write to register r is buffered or on the output stage

Behaviour:
- Reset (clk edge with reset=1):
  - Buffers empty, age flags cleared, RR pointer = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - req_ready = 2'b00 while reset is high; busy_mask = 0.
  - Reset mid-operation discards all buffered writes; none reach the port.
- req_ready[i]:
  - Equals !buf_valid[i] || grant[i], so a buffer drained this cycle can refill at the same edge.
  - Never depends on req_valid.
- Accept: a transfer with req_addr == ZERO_REG completes the handshake but does not load the buffer and never sets busy_mask.
- Grant (combinational, among valid buffers):
  - Only one buffer valid: grant it.
  - Both valid with the same addr: grant the older buffer. The age flag is set when a buffer loads while the other is already valid.
  - Both valid with different addrs: grant the RR-pointer side; the pointer then moves to the other side.
  - A single (uncontested) grant also sets the pointer to the other side.
- Output stage (registered):
  - On the edge after a grant: wr_en=1, wr_addr/wr_data from the granted buffer, and that buffer clears unless reloaded at the same edge.
  - No grant: wr_en=0; wr_addr/wr_data hold their previous values.
- Latency: handshake at edge E; wr_en is high in the cycle after edge E+1, and the register file writes at edge E+2. Uncontested throughput is 1 write/cycle per requester.
- Contention: both requesters streaming to different registers get 1 write per 2 cycles each, alternating; neither starves.
- busy_mask = OR of decoded buffer addrs (when valid) and decoded wr_addr (when wr_en). Purely a function of state.
- Simultaneous accept on both sides in the same cycle with equal addrs: requester 0 is treated as older (ALU precedes load in program order at writeback).

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=64, XZR=31.
  - typedef wr_req_t {addr, data}.
  - typedef enum req_id_t {REQ_ALU, REQ_MEM}.
- One sub-module, wr_req_buffer: a single-entry buffer with valid, load, clear, and stored wr_req_t. Instantiated twice.
- Arbitration, age/RR logic and the output register live in the top module.

Test Plan:
- Reset with req_valid=2'b11 held -> req_ready=0, wr_en=0, busy_mask=0. On release, ready=2'b11 next cycle.
- Req0 addr=3 data=64'hDEAD_BEEF at edge E -> busy_mask[3]=1 from E. wr_en=1, wr_addr=3, wr_data=64'hDEAD_BEEF in cycle after E+1. busy_mask[3]=0 after E+2.
- Both requesters valid every cycle, req0 addr=1, req1 addr=2, for 10 cycles -> wr_addr alternates 1,2,1,2 (pointer starts at 0). ready toggles so each side completes 5 transfers per 10 cycles.
- Req1 addr=7 data=A accepted one cycle before req0 addr=7 data=B -> port writes A then B, even when the RR pointer favours req0.
- Req0 addr=31 data=5 -> handshake completes, wr_en stays 0, busy_mask stays 0.
- Assert reset while both buffers hold writes (addr 4, 9) -> no wr_en pulse for 4 or 9 after reset; busy_mask=0.
